// File: rtl/aes_encrypt_iter_pkg.sv
// Shared AES-128 definitions: round count, state/FSM types, forward S-box and xtime.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef logic [15:0][7:0] state_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

    // Byte b of the S-box lives at bits [8*(255-b) +: 8]
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Block-in / key-fetch / block-out signal bundle of the iterative AES encryption core.
interface aes_encrypt_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] plaintext;
    logic [3:0]   round_key_idx;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] ciphertext;

    modport slave (
        input  in_valid, plaintext, round_key, out_ready,
        output in_ready, round_key_idx, out_valid, ciphertext
    );

    modport master (
        output in_valid, plaintext, round_key, out_ready,
        input  in_ready, round_key_idx, out_valid, ciphertext
    );
endinterface

// File: rtl/aes_encrypt_iter_shift_rows.sv
// Forward ShiftRows: row r of the state rotates left by r byte positions.
module shift_rows
    import aes_pkg::*;
(
    input  state_t data_i,
    output state_t data_o
);

    // Byte index 4*col+row maps to packed element 15-index
    always_comb begin
        data_o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                data_o[15 - (4 * c + r)] = data_i[15 - (4 * ((c + r) % 4) + r)];
            end
        end
    end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: initial AddRoundKey on acceptance, then one full round per clock.
module aes_encrypt_iter
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    aes_encrypt_iter_if.slave  bus
);

    fsm_e       fsm_q, fsm_d;
    logic [3:0] rnd_q, rnd_d;
    state_t     state_q, state_d;
    state_t     sb, sr, mc, rnd_out;

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        sb = '0;
        for (int k = 0; k < 16; k++) begin
            sb[k] = sbox(state_q[k]);
        end
    end

    shift_rows u_shift_rows (
        .data_i (sb),
        .data_o (sr)
    );

    always_comb begin
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[15 - 4 * c -: 4] = mix_col(sr[15 - 4 * c -: 4]);
        end
    end

    // The final round skips MixColumns
    assign rnd_out = ((rnd_q == NR) ? sr : mc) ^ bus.round_key;

    always_comb begin
        fsm_d   = fsm_q;
        rnd_d   = rnd_q;
        state_d = state_q;
        case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = bus.plaintext ^ bus.round_key;
                    rnd_d   = 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (rnd_q > NR) begin
                    fsm_d = IDLE;
                    rnd_d = 4'd0;
                end else begin
                    state_d = rnd_out;
                    if (rnd_q == NR) begin
                        fsm_d = DONE;
                        rnd_d = 4'd0;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
                rnd_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            rnd_q   <= rnd_d;
            state_q <= state_d;
        end
    end

    assign bus.in_ready      = (fsm_q == IDLE);
    assign bus.out_valid     = (fsm_q == DONE);
    assign bus.round_key_idx = (fsm_q == ROUND) ? rnd_q : 4'd0;
    assign bus.ciphertext    = state_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: key-store model, GF(2^8)-derived reference cipher and output scoreboard.
module tb_aes_encrypt_iter;

    localparam int NK = 6;
    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst;
    aes_encrypt_iter_if bus ();
    aes_encrypt_iter dut (.clk(clk), .rst(rst), .bus(bus));

    logic [127:0] sr_in, sr_out;
    shift_rows u_sr (.data_i(sr_in), .data_o(sr_out));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;
    logic [7:0]   sbt [256];
    logic [127:0] key_tab [NK];
    logic [127:0] rk_tab [NK][11];
    int key_next = 0;
    int key_cur = 0;
    logic [127:0] exp_q [$];
    int unsigned last_out_cyc = 0, prev_out_cyc = 0, acc_cyc = 0, dlt = 0;
    bit inflight = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    function automatic void build_sbox();
        logic [7:0] inv, av, xv;
        for (int a = 0; a < 256; a++) begin
            av = a[7:0];
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                xv = x[7:0];
                if (gmul(av, xv) == 8'h01) inv = xv;
            end
            sbt[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic void expand_key(input int ks);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc;
        logic [127:0] k;
        k = key_tab[ks];
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk_tab[ks][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input int ks);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] k, o;
        k = rk_tab[ks][0];
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ k[127 - 8 * i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[4 * c + rr] = t[4 * ((c + rr) % 4) + rr];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
                    s[4 * c + 3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
                end
            end
            k = rk_tab[ks][r];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127 - 8 * i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    // Key store: index 0 serves the block about to be accepted, 1..10 the block in flight
    always_comb begin
        bus.round_key = '0;
        if (bus.round_key_idx == 4'd0) bus.round_key = rk_tab[key_next][0];
        else if (bus.round_key_idx <= 4'd10) bus.round_key = rk_tab[key_cur][bus.round_key_idx];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid && bus.in_ready) key_cur <= key_next;
    end

    // Monitor: key-index sequence, latency and in-order ciphertext scoreboard
    always @(negedge clk) begin
        if (rst) begin
            inflight = 0;
        end else begin
            if (bus.in_ready) check("idle_key_idx", 128'(bus.round_key_idx), 128'd0);
            if (bus.in_valid && bus.in_ready) begin
                inflight = 1;
                acc_cyc = cyc;
            end else if (inflight) begin
                dlt = cyc - acc_cyc;
                if (dlt <= 10) begin
                    check("round_key_idx", 128'(bus.round_key_idx), 128'(dlt));
                    check("busy_flags", 128'({bus.in_ready, bus.out_valid}), 128'd0);
                end else begin
                    check("latency_out_valid", 128'(bus.out_valid), 128'd1);
                    inflight = 0;
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output", bus.ciphertext);
                end else begin
                    check("ciphertext", bus.ciphertext, exp_q.pop_front());
                end
                prev_out_cyc = last_out_cyc;
                last_out_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [127:0] pt, input int ks, input logic [127:0] exp,
                        input bit hold, output int unsigned acc);
        bit ok;
        bus.plaintext = pt;
        key_next = ks;
        bus.in_valid = 1'b1;
        ok = 0;
        acc = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected acceptance within 100 cycles");
        end else begin
            acc = cyc;
            exp_q.push_back(exp);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_bp);
        bit ok;
        ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) ok = 1;
            else if (rand_bp) bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int unsigned a1, a2, rel;
        logic [127:0] pt2;
        int k2;
        bit seen;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.plaintext = '0;
        bus.out_ready = 1'b1;
        build_sbox();
        key_tab[0] = 128'h000102030405060708090a0b0c0d0e0f;
        key_tab[1] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        for (int i = 2; i < NK; i++) key_tab[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < NK; i++) expand_key(i);
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 128'(bus.in_ready), 128'd1);
        check("reset_out_valid", 128'(bus.out_valid), 128'd0);
        check("reset_key_idx", 128'(bus.round_key_idx), 128'd0);
        check("reset_ciphertext", bus.ciphertext, 128'd0);
        check("model_c1", ref_enc(PT_C1, 0), CT_C1);
        check("model_appb", ref_enc(PT_B, 1), CT_B);
        sr_in = 128'h000102030405060708090a0b0c0d0e0f;
        #1;
        check("shift_rows_unit", sr_out, 128'h00050a0f04090e03080d02070c01060b);
        rst = 1'b0;
        @(posedge clk);
        #1;

        send(PT_C1, 0, CT_C1, 0, a1);
        drain(0);

        send(PT_B, 1, CT_B, 0, a1);
        check("appb_initial_ark", bus.ciphertext, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        @(posedge clk);
        #1;
        check("appb_round1_state", bus.ciphertext, 128'ha49c7ff2689f352b6b5bea43026a5049);
        drain(0);

        // Backpressure with a competing block held on the input
        bus.out_ready = 1'b0;
        send(PT_C1, 0, CT_C1, 0, a1);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check("bp_out_valid_seen", 128'(seen), 128'd1);
        k2 = int'($urandom_range(2, NK - 1));
        pt2 = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        bus.plaintext = pt2;
        key_next = k2;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid_hold", 128'(bus.out_valid), 128'd1);
            check("bp_ciphertext_hold", bus.ciphertext, CT_C1);
            check("bp_in_ready_low", 128'(bus.in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        rel = cyc;
        send(pt2, k2, ref_enc(pt2, k2), 0, a2);
        check("bp_accept_after_release", 128'(a2 - rel), 128'd1);
        drain(0);

        // Reset while round 5 is pending
        send(PT_C1, 0, CT_C1, 0, a1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_in_ready", 128'(bus.in_ready), 128'd1);
        check("midrst_out_valid", 128'(bus.out_valid), 128'd0);
        check("midrst_key_idx", 128'(bus.round_key_idx), 128'd0);
        check("midrst_ciphertext", bus.ciphertext, 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        send(PT_C1, 0, CT_C1, 0, a1);
        drain(0);

        // Back-to-back with in_valid held high
        send(PT_C1, 0, CT_C1, 1, a1);
        send(PT_B, 1, CT_B, 0, a2);
        check("b2b_accept_spacing", 128'(a2 - a1), 128'd12);
        drain(0);
        check("b2b_output_spacing", 128'(last_out_cyc - prev_out_cyc), 128'd12);

        // Random blocks and keys with random output backpressure
        for (int n = 0; n < 8; n++) begin
            k2 = int'($urandom_range(0, NK - 1));
            pt2 = {$urandom, $urandom, $urandom, $urandom};
            send(pt2, k2, ref_enc(pt2, k2), 0, a1);
            drain(1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
